imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//   Byte-stream program loader that sits directly upstream of cpu. It receives a framed
//   program image, assembles 32-bit little-endian words and writes them into the cpu's
//   instruction memory write port. It holds the cpu in reset until the frame checksum
//   verifies, replacing the static IMEM_FILE preload for board bring-up.
// PARAMETERS
//   ADDR_WIDTH  11     IMEM word-address width; capacity = 2**ADDR_WIDTH words (matches cpu)
//   SYNC_BYTE   8'hA5  frame start marker
// PORTS
//   clk         in   1           system clock, rising edge
//   reset       in   1           synchronous, active-low reset
//   rx_valid    in   1           byte strobe from UART/host
//   rx_data     in   8           byte payload
//   rx_ready    out  1           loader accepts a byte when rx_valid & rx_ready
//   imem_we     out  1           one-cycle IMEM write strobe
//   imem_addr   out  ADDR_WIDTH  IMEM word address
//   imem_wdata  out  32          IMEM write data
//   cpu_reset   out  1           active-high reset to cpu; high until load verified
//   load_done   out  1           sticky: image loaded and checksum matched
//   load_error  out  1           sticky: length overflow or checksum mismatch
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=IDLE, rx_ready=1, imem_we=0, imem_addr=0,
//   imem_wdata=0, cpu_reset=1, load_done=0, load_error=0, byte counter=0, checksum=0.
//   A reset mid-frame discards the partial frame. Words already written stay in IMEM.
// - Frame format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count N), 4*N data bytes
//   (LSB first per word), CSUM byte = XOR of all 4*N data bytes.
// - FSM:
//   - IDLE: non-SYNC bytes are accepted and dropped. SYNC -> LEN_LO.
//   - LEN_LO -> LEN_HI.
//   - LEN_HI: N > 2**ADDR_WIDTH -> ERR. N==0 -> CSUM. Otherwise -> DATA.
//   - DATA: shift each byte into bits [8k+7:8k]. On the 4th byte, register the word.
//     - The next cycle: imem_we=1, imem_wdata=word, imem_addr=word index (0..N-1).
//     - After the N-th word -> CSUM.
//   - CSUM: a byte equal to the running XOR -> DONE; otherwise -> ERR.
//   - DONE: load_done=1. cpu_reset drops to 0 on the cycle after entry. rx_ready=0.
//     The state is terminal until reset.
//   - ERR: load_error=1, cpu_reset stays 1, rx_ready=0. The state is terminal until reset.
// - rx_ready=1 in IDLE/LEN_LO/LEN_HI/DATA/CSUM, including the imem_we cycle.
//   Back-to-back bytes every cycle are supported with no stalls.
// - rx_valid with rx_ready=0 is ignored (byte dropped, no state change).
// - imem_addr holds the last written address between writes. The counter is ADDR_WIDTH+1
//   bits, so N == 2**ADDR_WIDTH writes the last word at the top address without wrap.
// - The checksum covers data bytes only. The length and sync bytes are excluded.
// STRUCTURE
// - Shared package/header: loader FSM state encodings, SYNC_BYTE default, and the frame
//   field byte offsets. The cpu testbench reuses these to build frames.
// - One sub-module: word_assembler (byte shifter + lane counter + word_valid pulse).
//   The FSM, address counter and checksum stay in this module.
// - Top-level integration: imem gains a write port driven by imem_*.
//   cpu.reset = cpu_reset | ~board_reset_n.
// TESTING
// 1. Nominal load:
//    - Stream: A5 02 00 | 13 03 00 01 | 6F 00 00 00 | CSUM.
//      The CSUM byte is the XOR of the eight data bytes, 13^03^00^01^6F^00^00^00 = 0x7E.
//    - Expect imem_we at words 0x01000313 (addr 0) and 0x0000006F (addr 1), load_done=1,
//      and cpu_reset=0 one cycle later.
//    - The cpu then reaches jal x0,0.
// 2. Bad checksum:
//    - Same frame with CSUM = 0x7F.
//    - Expect two writes, then load_error=1, cpu_reset held 1, rx_ready=0.
// 3. Garbage and zero length:
//    - Stream: 00 FF 5A A5 00 00 00.
//    - Expect leading bytes dropped, no imem_we, load_done=1.
// 4. Overflow:
//    - With ADDR_WIDTH=4, send LEN = 0x0011.
//    - Expect load_error=1 immediately after LEN_HI and no writes.
//    - With LEN = 0x0010 and valid data, the last write is at addr 0xF and load_done=1.
// 5. Reset mid-frame:
//    - Pulse reset low after 6 data bytes, then send a full valid frame.
//    - Expect all outputs at reset values, then a correct load from addr 0.
// 6. Throughput and gaps:
//    - Send bytes on consecutive cycles, then with random rx_valid gaps.
//    - Expect identical IMEM contents and no dropped bytes.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the IMEM boot loader: FSM states, default sync marker and frame layout.
// Testbenches reuse the field offsets to build frames.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCsum,
    StDone,
    StErr
  } loader_state_e;

  localparam logic [7:0] SyncByteDefault = 8'hA5;

  // Byte offsets of frame fields relative to the sync byte.
  localparam int unsigned OffSync  = 0;
  localparam int unsigned OffLenLo = 1;
  localparam int unsigned OffLenHi = 2;
  localparam int unsigned OffData  = 3;

  function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs little-endian bytes into 32-bit words; word_valid_o pulses with the fourth byte and
// word_o then carries the completed word combinationally.
module imem_boot_loader_word_assembler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clear_i) begin
      lane_d  = 2'd0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      lane_d = lane_q + 2'd1;
      unique case (lane_q)
        2'd0: shift_d[7:0]   = byte_i;
        2'd1: shift_d[15:8]  = byte_i;
        2'd2: shift_d[23:16] = byte_i;
        2'd3: shift_d        = '0;
      endcase
    end
  end

  assign word_valid_o = byte_valid_i & ~clear_i & (lane_q == 2'd3);
  assign word_o       = {byte_i, shift_q};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lane_q  <= 2'd0;
      shift_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader: writes a program image into IMEM and releases cpu reset once the
// XOR checksum of the data bytes verifies.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter logic [7:0]  SYNC_BYTE  = SyncByteDefault
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [16:0] MaxWords = 17'(1) << ADDR_WIDTH;

  loader_state_e         state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           len_q, len_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [7:0]            csum_q, csum_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;

  logic        accept;
  logic [15:0] len_full;
  logic        last_word;
  logic        asm_clear;
  logic        asm_byte_valid;
  logic        word_valid;
  logic [31:0] word;

  assign rx_ready       = (state_q != StDone) && (state_q != StErr);
  assign accept         = rx_valid & rx_ready;
  assign len_full       = {rx_data, len_lo_q};
  assign last_word      = (17'(cnt_q) + 17'd1) == {1'b0, len_q};
  assign asm_clear      = accept & (state_q == StLenHi);
  assign asm_byte_valid = accept & (state_q == StData);

  imem_boot_loader_word_assembler u_word_assembler (
    .clk_i        (clk),
    .rst_ni       (reset),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_byte_valid),
    .byte_i       (rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_reset_d  = cpu_reset_q;

    unique case (state_q)
      StIdle: begin
        if (accept && (rx_data == SYNC_BYTE)) begin
          state_d = StLenLo;
          csum_d  = '0;
          cnt_d   = '0;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d = len_full;
          if ({1'b0, len_full} > MaxWords) begin
            state_d = StErr;
          end else if (len_full == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          csum_d = csum_update(csum_q, rx_data);
        end
        // Word is registered here so the write strobe appears on the following cycle.
        if (word_valid) begin
          imem_we_d    = 1'b1;
          imem_wdata_d = word;
          imem_addr_d  = cnt_q[ADDR_WIDTH-1:0];
          cnt_d        = cnt_q + 1'b1;
          if (last_word) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? StDone : StErr;
        end
      end
      StDone: begin
        cpu_reset_d = 1'b0;
      end
      StErr: begin
        cpu_reset_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    load_done_d  = load_done_q | (state_d == StDone);
    load_error_d = load_error_q | (state_d == StErr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      len_lo_q     <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      csum_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      csum_q       <= csum_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule
